chacha_poly_msg_seq: RTL and testbench
======================================

Name: chacha_poly_msg_seq

Overview:
Message sequencer placed in front of the ChaCha20-Poly1305 tag adapter. It sequences one AEAD message as AAD beats, then ciphertext beats, then exactly one length block. It zero-pads each section's final partial beat to a full 16-byte Poly1305 block and counts section bytes. It generates the little-endian length block, drives the section-done levels that advance the adapter, and waits for the tag before reporting done.

Parameters:
CNT_W, 64, width of the AAD and ciphertext byte counters. Counters wrap modulo 2^CNT_W; length-block fields are zero-extended to 64 bits.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse; begins a message when algo_sel=1 and FSM is in IDLE, DONE or ERR
algo_sel  in  1  1 = ChaCha mode; start is ignored when 0
aad_empty  in  1  sampled at start; message has no AAD
pld_empty  in  1  sampled at start; message has no ciphertext
s_aad_valid / s_aad_ready  in / out  1 / 1  upstream AAD handshake
s_aad_data  in  128  AAD beat, byte i at bits [8i+7:8i]
s_aad_keep  in  16  byte enables
s_aad_last  in  1  final AAD beat
s_pld_valid / s_pld_ready  in / out  1 / 1  upstream ciphertext handshake
s_pld_data / s_pld_keep / s_pld_last  in  128 / 16 / 1  same conventions as the AAD stream
m_aad_valid / m_aad_ready  out / in  1 / 1  downstream AAD handshake
m_aad_data / m_aad_keep  out  128 / 16  padded AAD block
m_pld_valid / m_pld_ready  out / in  1 / 1  downstream ciphertext handshake
m_pld_data / m_pld_keep  out  128 / 16  padded ciphertext block
m_len_valid / m_len_ready  out / in  1 / 1  length-block handshake
m_len_block  out  128  {le64 ct_bytes, le64 aad_bytes}
aad_done  out  1  level; AAD section complete
pld_done  out  1  level; ciphertext section complete
tag_valid  in  1  pulse from the adapter when the tag pre-XOR value is ready
busy  out  1  high in AAD, PLD, LEN, WAIT_TAG
done  out  1  1-cycle pulse on tag_valid in WAIT_TAG
err  out  1  sticky protocol error flag
aad_bytes / pld_bytes  out  CNT_W / CNT_W  running byte counts

Behaviour:
- Reset values: state=IDLE; all outputs 0; counters 0; m_len_block 0.
- Transfer rule: a beat transfers when valid and ready are both high on a clock edge.
- Pass-through is combinational, zero latency:
  - In AAD: m_aad_valid=s_aad_valid and s_aad_ready=m_aad_ready.
  - In PLD: the same for the pld streams.
  - In every other state the corresponding valid/ready are 0.
- Output data = input data with bytes where keep=0 forced to 0x00. Output keep is always 16'hFFFF, so every block is a full zero-padded Poly1305 block.
- Legal keep values:
  - Last beat: contiguous from bit 0 (2^n-1, n=1..16).
  - Non-last beat: must be 16'hFFFF.
- Any other keep on a beat presented with valid:
  - Goes to ERR the next cycle and sets err.
  - The beat is not transferred (ready forced 0 that cycle).
  - Counters are not updated.
- Counters:
  - aad_bytes/pld_bytes add popcount(keep) per transfer, wrapping.
  - Both are cleared on an accepted start.
  - In DONE they hold their final values until the next accepted start.
- FSM, on an accepted start:
  - Clears counters, err, aad_done and pld_done.
  - Goes to AAD, or directly to PLD with aad_done=1 if aad_empty.
  - If both aad_empty and pld_empty: goes to LEN with aad_done=pld_done=1.
- AAD:
  - Transfer with last sets aad_done=1 (registered, visible next cycle).
  - Next state is PLD, or LEN with pld_done=1 if pld_empty was sampled.
- PLD: transfer with last sets pld_done=1; next state LEN.
- LEN:
  - m_len_valid=1 and m_len_block={zext64(pld_bytes), zext64(aad_bytes)}, stable while valid.
  - On transfer, go to WAIT_TAG.
- WAIT_TAG: on tag_valid, pulse done for 1 cycle and go to DONE. tag_valid in any other state is ignored.
- DONE / ERR:
  - All readies and valids are 0; aad_done, pld_done and err hold.
  - An accepted start restarts the message.
- A start while busy is ignored. A start with algo_sel=0 is ignored in every state.
- rst asserted mid-message: immediate return to reset values; a partially transferred message is discarded.

Decomposition:
- Shared package (chacha_poly_pkg):
  - State encoding (IDLE, AAD, PLD, LEN, WAIT_TAG, DONE, ERR).
  - BLK_BYTES=16, KEEP_FULL=16'hFFFF.
  - Functions keep_is_contig and keep_popcount.
- One sub-module: chacha_poly_lane_pad. It is combinational; it masks data, validates keep against last, and returns the byte count. It is instantiated twice, once for AAD and once for PLD.

Test Plan:
- RFC 8439 sizes, AAD 12 bytes (1 beat, keep 0x0FFF, last) and ct 114 bytes (7 full beats plus keep 0x0003) -> 1 AAD, 8 PLD and 1 len block transfers, every output keep FFFF. m_len_block[63:0]=0x0C and [127:64]=0x72. aad_done rises the cycle after the AAD transfer. done pulses once after tag_valid.
- start with aad_empty=1 and pld_empty=1 -> no AAD/PLD transfers; m_len_valid the cycle after start with m_len_block=0. aad_done=pld_done=1. done follows tag_valid.
- Random m_*_ready backpressure (50%) on a 40B AAD / 33B ct message -> byte-exact data preserved, no duplicate or dropped beats, m_len_block={0x21, 0x28}.
- AAD beat with keep 0x00F0, and separately a non-last beat with keep 0x7FFF -> err=1, state ERR, beat not transferred, counters unchanged. The next start clears err.
- rst pulse mid-PLD (after 3 beats) -> all outputs 0 immediately. A fresh message afterwards produces the correct length block.
- start pulses during PLD, and start with algo_sel=0 in IDLE -> no state change and counters untouched.

Source files
------------

// File: rtl/chacha_poly_pkg.sv
// ---------------------------------------------------------------------------
// chacha_poly_pkg
// Shared definitions for the ChaCha20-Poly1305 message sequencer:
//   - seq_state_t    : message sequencer state encoding
//   - BLK_BYTES      : Poly1305 block size in bytes
//   - KEEP_FULL      : byte-enable pattern of a full block
//   - keep_is_contig : true when a keep mask is 2^n-1 with n in 1..16
//   - keep_popcount  : number of enabled bytes in a keep mask
// ---------------------------------------------------------------------------
package chacha_poly_pkg;

  localparam int          BLK_BYTES = 16;
  localparam logic [15:0] KEEP_FULL = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_AAD      = 3'd1,
    ST_PLD      = 3'd2,
    ST_LEN      = 3'd3,
    ST_WAIT_TAG = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } seq_state_t;

  // A mask of the form 2^n-1 has no set bit above a clear bit, so adding
  // one clears every set bit (FFFF wraps to 0, which also qualifies).
  function automatic logic keep_is_contig(input logic [15:0] keep);
    return (keep != 16'h0000) && ((keep & (keep + 16'h0001)) == 16'h0000);
  endfunction

  function automatic logic [4:0] keep_popcount(input logic [15:0] keep);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/chacha_poly_lane_pad.sv
// ---------------------------------------------------------------------------
// chacha_poly_lane_pad
// Combinational per-stream helper. Zero-fills disabled bytes so every block
// leaving the sequencer is a full zero-padded Poly1305 block, checks that the
// keep mask is legal for the beat position, and reports the enabled-byte count.
// Ports:
//   data     in  128  incoming beat, byte i at [8i+7:8i]
//   keep     in  16   byte enables
//   last     in  1    beat is the final one of its section
//   data_pad out 128  data with disabled bytes forced to 0x00
//   keep_ok  out 1    last: contiguous from bit 0; otherwise: all ones
//   byte_cnt out 5    popcount(keep)
// ---------------------------------------------------------------------------
module chacha_poly_lane_pad
  import chacha_poly_pkg::*;
(
  input  logic [127:0] data,
  input  logic [15:0]  keep,
  input  logic         last,
  output logic [127:0] data_pad,
  output logic         keep_ok,
  output logic [4:0]   byte_cnt
);

  // Byte-wise zero fill of lanes whose enable is clear.
  always_comb begin
    data_pad = '0;
    for (int i = 0; i < BLK_BYTES; i++) begin
      if (keep[i]) begin
        data_pad[8*i +: 8] = data[8*i +: 8];
      end
    end
  end

  // Only the final beat of a section may be partial; earlier beats must be
  // full so the byte stream stays aligned to 16-byte blocks.
  assign keep_ok  = last ? keep_is_contig(keep) : (keep == KEEP_FULL);
  assign byte_cnt = keep_popcount(keep);

endmodule

// File: rtl/chacha_poly_msg_seq.sv
// ---------------------------------------------------------------------------
// chacha_poly_msg_seq
// Sequences one ChaCha20-Poly1305 AEAD message in front of the tag adapter:
// AAD beats, then ciphertext beats, then one little-endian length block.
// Partial final beats are zero-padded to full blocks and section byte counts
// are accumulated for the length block.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, algo_sel               message start pulse, ChaCha mode select
//   aad_empty, pld_empty          sampled at start: section has no data
//   s_aad_* / s_pld_*             upstream streams (valid/ready/data/keep/last)
//   m_aad_* / m_pld_*             padded downstream blocks (valid/ready/data/keep)
//   m_len_valid/ready/block       {le64 ct_bytes, le64 aad_bytes}
//   aad_done, pld_done            section-complete levels for the adapter
//   tag_valid                     tag ready pulse from the adapter
//   busy, done, err               status: in message, finished pulse, sticky error
//   aad_bytes, pld_bytes          running section byte counts
// ---------------------------------------------------------------------------
module chacha_poly_msg_seq
  import chacha_poly_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             algo_sel,
  input  logic             aad_empty,
  input  logic             pld_empty,
  input  logic             s_aad_valid,
  output logic             s_aad_ready,
  input  logic [127:0]     s_aad_data,
  input  logic [15:0]      s_aad_keep,
  input  logic             s_aad_last,
  input  logic             s_pld_valid,
  output logic             s_pld_ready,
  input  logic [127:0]     s_pld_data,
  input  logic [15:0]      s_pld_keep,
  input  logic             s_pld_last,
  output logic             m_aad_valid,
  input  logic             m_aad_ready,
  output logic [127:0]     m_aad_data,
  output logic [15:0]      m_aad_keep,
  output logic             m_pld_valid,
  input  logic             m_pld_ready,
  output logic [127:0]     m_pld_data,
  output logic [15:0]      m_pld_keep,
  output logic             m_len_valid,
  input  logic             m_len_ready,
  output logic [127:0]     m_len_block,
  output logic             aad_done,
  output logic             pld_done,
  input  logic             tag_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] aad_bytes,
  output logic [CNT_W-1:0] pld_bytes
);

  seq_state_t   state;
  logic         pld_empty_q;

  logic [127:0] aad_pad;
  logic [127:0] pld_pad;
  logic         aad_keep_ok;
  logic         pld_keep_ok;
  logic [4:0]   aad_cnt;
  logic [4:0]   pld_cnt;

  logic         in_aad;
  logic         in_pld;
  logic         aad_bad;
  logic         pld_bad;
  logic         aad_xfer;
  logic         pld_xfer;
  logic         len_xfer;
  logic         start_ok;
  logic [63:0]  aad_len64;
  logic [63:0]  pld_len64;

  chacha_poly_lane_pad u_aad_pad (
    .data     (s_aad_data),
    .keep     (s_aad_keep),
    .last     (s_aad_last),
    .data_pad (aad_pad),
    .keep_ok  (aad_keep_ok),
    .byte_cnt (aad_cnt)
  );

  chacha_poly_lane_pad u_pld_pad (
    .data     (s_pld_data),
    .keep     (s_pld_keep),
    .last     (s_pld_last),
    .data_pad (pld_pad),
    .keep_ok  (pld_keep_ok),
    .byte_cnt (pld_cnt)
  );

  assign in_aad = (state == ST_AAD);
  assign in_pld = (state == ST_PLD);

  // A beat with an illegal keep is refused on both sides: upstream sees no
  // ready and downstream sees no valid, so nothing is consumed or forwarded.
  assign aad_bad = in_aad && s_aad_valid && !aad_keep_ok;
  assign pld_bad = in_pld && s_pld_valid && !pld_keep_ok;

  assign m_aad_valid = in_aad && s_aad_valid && aad_keep_ok;
  assign s_aad_ready = in_aad && m_aad_ready && !aad_bad;
  assign m_aad_data  = in_aad ? aad_pad : '0;
  assign m_aad_keep  = in_aad ? KEEP_FULL : '0;

  assign m_pld_valid = in_pld && s_pld_valid && pld_keep_ok;
  assign s_pld_ready = in_pld && m_pld_ready && !pld_bad;
  assign m_pld_data  = in_pld ? pld_pad : '0;
  assign m_pld_keep  = in_pld ? KEEP_FULL : '0;

  assign aad_xfer = m_aad_valid && m_aad_ready;
  assign pld_xfer = m_pld_valid && m_pld_ready;

  // Counters do not move while in LEN, so the block is stable while valid.
  assign aad_len64   = 64'(aad_bytes);
  assign pld_len64   = 64'(pld_bytes);
  assign m_len_valid = (state == ST_LEN);
  assign m_len_block = m_len_valid ? {pld_len64, aad_len64} : '0;
  assign len_xfer    = m_len_valid && m_len_ready;

  assign busy = (state == ST_AAD) || (state == ST_PLD) ||
                (state == ST_LEN) || (state == ST_WAIT_TAG);

  assign start_ok = start && algo_sel &&
                    ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

  // Message FSM with section flags, counters and status outputs. Section
  // done levels are set on the transfer of the last beat and are therefore
  // visible the cycle after that transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pld_empty_q <= 1'b0;
      aad_done    <= 1'b0;
      pld_done    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      aad_bytes   <= '0;
      pld_bytes   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_ok) begin
            aad_bytes   <= '0;
            pld_bytes   <= '0;
            err         <= 1'b0;
            pld_empty_q <= pld_empty;
            aad_done    <= aad_empty;
            pld_done    <= aad_empty && pld_empty;
            if (!aad_empty) begin
              state <= ST_AAD;
            end else if (!pld_empty) begin
              state <= ST_PLD;
            end else begin
              state <= ST_LEN;
            end
          end
        end

        ST_AAD: begin
          if (aad_bad) begin
            err   <= 1'b1;
            state <= ST_ERR;
          end else if (aad_xfer) begin
            aad_bytes <= aad_bytes + CNT_W'(aad_cnt);
            if (s_aad_last) begin
              aad_done <= 1'b1;
              if (pld_empty_q) begin
                pld_done <= 1'b1;
                state    <= ST_LEN;
              end else begin
                state <= ST_PLD;
              end
            end
          end
        end

        ST_PLD: begin
          if (pld_bad) begin
            err   <= 1'b1;
            state <= ST_ERR;
          end else if (pld_xfer) begin
            pld_bytes <= pld_bytes + CNT_W'(pld_cnt);
            if (s_pld_last) begin
              pld_done <= 1'b1;
              state    <= ST_LEN;
            end
          end
        end

        ST_LEN: begin
          if (len_xfer) begin
            state <= ST_WAIT_TAG;
          end
        end

        ST_WAIT_TAG: begin
          if (tag_valid) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_poly_msg_seq.sv
// ---------------------------------------------------------------------------
// tb_chacha_poly_msg_seq
// Self-checking bench: random message bytes are split into 16-byte beats and
// the expected padded blocks, counts and length block are derived from the
// byte lengths alone.
// ---------------------------------------------------------------------------
module tb_chacha_poly_msg_seq;

  localparam int CNT_W = 64;

  logic             clk;
  logic             rst;
  logic             start;
  logic             algo_sel;
  logic             aad_empty;
  logic             pld_empty;
  logic             s_aad_valid;
  logic             s_aad_ready;
  logic [127:0]     s_aad_data;
  logic [15:0]      s_aad_keep;
  logic             s_aad_last;
  logic             s_pld_valid;
  logic             s_pld_ready;
  logic [127:0]     s_pld_data;
  logic [15:0]      s_pld_keep;
  logic             s_pld_last;
  logic             m_aad_valid;
  logic             m_aad_ready;
  logic [127:0]     m_aad_data;
  logic [15:0]      m_aad_keep;
  logic             m_pld_valid;
  logic             m_pld_ready;
  logic [127:0]     m_pld_data;
  logic [15:0]      m_pld_keep;
  logic             m_len_valid;
  logic             m_len_ready;
  logic [127:0]     m_len_block;
  logic             aad_done;
  logic             pld_done;
  logic             tag_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] aad_bytes;
  logic [CNT_W-1:0] pld_bytes;

  int errors = 0;
  int checks = 0;

  chacha_poly_msg_seq #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .algo_sel    (algo_sel),
    .aad_empty   (aad_empty),
    .pld_empty   (pld_empty),
    .s_aad_valid (s_aad_valid),
    .s_aad_ready (s_aad_ready),
    .s_aad_data  (s_aad_data),
    .s_aad_keep  (s_aad_keep),
    .s_aad_last  (s_aad_last),
    .s_pld_valid (s_pld_valid),
    .s_pld_ready (s_pld_ready),
    .s_pld_data  (s_pld_data),
    .s_pld_keep  (s_pld_keep),
    .s_pld_last  (s_pld_last),
    .m_aad_valid (m_aad_valid),
    .m_aad_ready (m_aad_ready),
    .m_aad_data  (m_aad_data),
    .m_aad_keep  (m_aad_keep),
    .m_pld_valid (m_pld_valid),
    .m_pld_ready (m_pld_ready),
    .m_pld_data  (m_pld_data),
    .m_pld_keep  (m_pld_keep),
    .m_len_valid (m_len_valid),
    .m_len_ready (m_len_ready),
    .m_len_block (m_len_block),
    .aad_done    (aad_done),
    .pld_done    (pld_done),
    .tag_valid   (tag_valid),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .aad_bytes   (aad_bytes),
    .pld_bytes   (pld_bytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute guard so the run always ends even if a handshake never comes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counted, asserted, reported with tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the control inputs for one clock, then drop start.
  task automatic applyStimulus(input logic st, input logic alg, input logic ae, input logic pe);
    start     = st;
    algo_sel  = alg;
    aad_empty = ae;
    pld_empty = pe;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idleStreams();
    s_aad_valid = 1'b0; s_aad_data = '0; s_aad_keep = '0; s_aad_last = 1'b0;
    s_pld_valid = 1'b0; s_pld_data = '0; s_pld_keep = '0; s_pld_last = 1'b0;
    m_aad_ready = 1'b0; m_pld_ready = 1'b0; m_len_ready = 1'b0;
    tag_valid   = 1'b0;
  endtask

  // Split a byte string into beats: driven data has random garbage in the
  // disabled lanes, expected data has zeros there.
  task automatic buildBeats(input int len,
                            output logic [127:0] d[$], output logic [127:0] e[$],
                            output logic [15:0] k[$], output bit l[$]);
    int nb;
    d.delete(); e.delete(); k.delete(); l.delete();
    nb = (len + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      logic [127:0] dd;
      logic [127:0] ee;
      logic [15:0]  kk;
      int           n;
      dd = '0; ee = '0; kk = '0;
      n = len - b * 16;
      if (n > 16) n = 16;
      for (int i = 0; i < 16; i++) begin
        logic [7:0] byt;
        byt = 8'($urandom);
        dd[8*i +: 8] = byt;
        if (i < n) begin
          ee[8*i +: 8] = byt;
          kk[i] = 1'b1;
        end
      end
      d.push_back(dd); e.push_back(ee); k.push_back(kk); l.push_back(b == nb - 1);
    end
  endtask

  // Run one message. abort_pld >= 0 returns after that many ciphertext
  // transfers; poke_start pulses start during the ciphertext section.
  task automatic runMessage(input int aad_len, input int pld_len, input bit bp,
                            input int abort_pld, input bit poke_start);
    logic [127:0] ad[$], ae_q[$], pd[$], pe_q[$];
    logic [15:0]  ak[$], pk[$];
    bit           al[$], pl[$];
    logic [127:0] got_aad[$], got_pld[$];
    logic [127:0] exp_len;
    int           ai, pi, keep_bad;
    bit           len_seen, aad_pending, poked;

    buildBeats(aad_len, ad, ae_q, ak, al);
    buildBeats(pld_len, pd, pe_q, pk, pl);
    exp_len = {64'(pld_len), 64'(aad_len)};
    ai = 0; pi = 0; keep_bad = 0;
    len_seen = 1'b0; aad_pending = 1'b0; poked = 1'b0;
    got_aad.delete(); got_pld.delete();

    idleStreams();
    applyStimulus(1'b1, 1'b1, aad_len == 0, pld_len == 0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_aad_valid = (ai < ad.size());
      if (ai < ad.size()) begin
        s_aad_data = ad[ai]; s_aad_keep = ak[ai]; s_aad_last = al[ai];
      end
      s_pld_valid = (pi < pd.size());
      if (pi < pd.size()) begin
        s_pld_data = pd[pi]; s_pld_keep = pk[pi]; s_pld_last = pl[pi];
      end
      m_aad_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_pld_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_len_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_start && !poked && pi == 1) begin
        start = 1'b1;
        poked = 1'b1;
      end

      @(negedge clk);
      if (cyc == 0 && aad_len == 0 && pld_len == 0) begin
        checkOutput("empty_len_valid", 128'(m_len_valid), 128'(1));
        checkOutput("empty_aad_done", 128'(aad_done), 128'(1));
        checkOutput("empty_pld_done", 128'(pld_done), 128'(1));
      end
      if (aad_pending) begin
        checkOutput("aad_done_after_last", 128'(aad_done), 128'(1));
        aad_pending = 1'b0;
      end
      if (s_aad_valid && s_aad_ready) begin
        if (ai == ad.size() - 1) begin
          checkOutput("aad_done_before_last", 128'(aad_done), 128'(0));
          aad_pending = 1'b1;
        end
        ai++;
      end
      if (s_pld_valid && s_pld_ready) pi++;
      if (m_aad_valid && m_aad_ready) begin
        got_aad.push_back(m_aad_data);
        if (m_aad_keep !== 16'hFFFF) keep_bad++;
      end
      if (m_pld_valid && m_pld_ready) begin
        got_pld.push_back(m_pld_data);
        if (m_pld_keep !== 16'hFFFF) keep_bad++;
      end
      if (m_len_valid) begin
        checkOutput("len_block", m_len_block, exp_len);
        if (m_len_ready) len_seen = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (abort_pld >= 0 && pi >= abort_pld) return;
      if (len_seen) break;
    end

    idleStreams();
    checkOutput("len_handshake_seen", 128'(len_seen), 128'(1));
    checkOutput("aad_block_count", 128'(got_aad.size()), 128'(ae_q.size()));
    checkOutput("pld_block_count", 128'(got_pld.size()), 128'(pe_q.size()));
    for (int i = 0; i < got_aad.size() && i < ae_q.size(); i++)
      checkOutput("aad_block_data", got_aad[i], ae_q[i]);
    for (int i = 0; i < got_pld.size() && i < pe_q.size(); i++)
      checkOutput("pld_block_data", got_pld[i], pe_q[i]);
    checkOutput("out_keep_full", 128'(keep_bad), 128'(0));

    // Waiting for the tag: still busy, no done until tag_valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("wait_tag_busy", 128'(busy), 128'(1));
    checkOutput("wait_tag_no_done", 128'(done), 128'(0));
    @(posedge clk);
    #1;
    tag_valid = 1'b1;
    @(posedge clk);
    #1;
    tag_valid = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", 128'(done), 128'(1));
    checkOutput("done_not_busy", 128'(busy), 128'(0));
    checkOutput("final_aad_bytes", 128'(aad_bytes), 128'(aad_len));
    checkOutput("final_pld_bytes", 128'(pld_bytes), 128'(pld_len));
    checkOutput("final_aad_done", 128'(aad_done), 128'(1));
    checkOutput("final_pld_done", 128'(pld_done), 128'(1));
    @(negedge clk);
    checkOutput("done_one_cycle", 128'(done), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; algo_sel = 1'b0; aad_empty = 1'b0; pld_empty = 1'b0;
    idleStreams();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_done", 128'(done), 128'(0));
    checkOutput("reset_err", 128'(err), 128'(0));
    checkOutput("reset_aad_done", 128'(aad_done), 128'(0));
    checkOutput("reset_len_valid", 128'(m_len_valid), 128'(0));
    checkOutput("reset_len_block", m_len_block, 128'(0));
    checkOutput("reset_aad_bytes", 128'(aad_bytes), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] start with algo_sel=0 in IDLE");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("algo0_idle_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1;

    $display("[TB] RFC 8439 sized message 12/114");
    runMessage(12, 114, 1'b0, -1, 1'b0);

    $display("[TB] empty AAD and ciphertext");
    runMessage(0, 0, 1'b0, -1, 1'b0);

    $display("[TB] backpressure 40/33");
    runMessage(40, 33, 1'b1, -1, 1'b0);

    $display("[TB] start with algo_sel=0 in DONE");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("algo0_done_busy", 128'(busy), 128'(0));
    checkOutput("algo0_done_aad_bytes", 128'(aad_bytes), 128'(40));
    checkOutput("algo0_done_pld_bytes", 128'(pld_bytes), 128'(33));
    @(posedge clk);
    #1;

    $display("[TB] illegal last keep 0x00F0");
    idleStreams();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    s_aad_valid = 1'b1; s_aad_data = {$urandom, $urandom, $urandom, $urandom};
    s_aad_keep = 16'h00F0; s_aad_last = 1'b1; m_aad_ready = 1'b1;
    @(negedge clk);
    checkOutput("badkeep_ready_low", 128'(s_aad_ready), 128'(0));
    @(posedge clk);
    #1;
    idleStreams();
    @(negedge clk);
    checkOutput("badkeep_err", 128'(err), 128'(1));
    checkOutput("badkeep_not_busy", 128'(busy), 128'(0));
    checkOutput("badkeep_aad_bytes", 128'(aad_bytes), 128'(0));
    @(posedge clk);
    #1;

    $display("[TB] illegal non-last keep 0x7FFF after one good beat");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("restart_clears_err", 128'(err), 128'(0));
    @(posedge clk);
    #1;
    s_aad_valid = 1'b1; s_aad_data = {$urandom, $urandom, $urandom, $urandom};
    s_aad_keep = 16'hFFFF; s_aad_last = 1'b0; m_aad_ready = 1'b1;
    @(posedge clk);
    #1;
    s_aad_keep = 16'h7FFF;
    @(negedge clk);
    checkOutput("nonlast_ready_low", 128'(s_aad_ready), 128'(0));
    @(posedge clk);
    #1;
    idleStreams();
    @(negedge clk);
    checkOutput("nonlast_err", 128'(err), 128'(1));
    checkOutput("nonlast_aad_bytes", 128'(aad_bytes), 128'(16));
    @(posedge clk);
    #1;

    $display("[TB] reset after 3 ciphertext beats");
    runMessage(20, 100, 1'b0, 3, 1'b0);
    idleStreams();
    rst = 1'b1;
    #2;
    checkOutput("midrst_busy", 128'(busy), 128'(0));
    checkOutput("midrst_aad_done", 128'(aad_done), 128'(0));
    checkOutput("midrst_pld_bytes", 128'(pld_bytes), 128'(0));
    checkOutput("midrst_aad_bytes", 128'(aad_bytes), 128'(0));
    checkOutput("midrst_pld_ready", 128'(s_pld_ready), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] fresh message with start pulsed during ciphertext");
    runMessage(5, 17, 1'b1, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
